// File: rtl/pc_sequencer_if.sv
// Sequencer-side bundle: stall/redirect controls in, fetch address and status out.
// STALL_COUNT_EN adds the stall_cycles counter output.
interface pc_sequencer_if #(
    parameter int OFFSET_W = 8
);
    logic                i_busy;
    logic                d_busy;
    logic                jump_en;
    logic                branch_en;
    logic [OFFSET_W-1:0] offset;
    logic [31:0]         pc;
    logic                pc_valid;
    logic                stall;
    logic                redirect_pending;
`ifdef STALL_COUNT_EN
    logic [15:0]         stall_cycles;
`endif

    modport master (
        output i_busy, d_busy, jump_en, branch_en, offset,
        input  pc, pc_valid, stall, redirect_pending
`ifdef STALL_COUNT_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  i_busy, d_busy, jump_en, branch_en, offset,
        output pc, pc_valid, stall, redirect_pending
`ifdef STALL_COUNT_EN
        , output stall_cycles
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC+4 / PC-relative redirect, holds on cache busy, one-edge latency.
// A redirect seen on the edge that enters a stall is parked and applied on release; STALL_COUNT_EN adds a saturating stall counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hFFFF_FFFC,
    parameter int          OFFSET_W = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {HOLD, RUN, STALL} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        pend_q;
    logic [31:0] pend_tgt;
    logic        stall;
    logic        redir;
    logic [31:0] seq;
    logic [31:0] off_ext;
    logic [31:0] tgt;
`ifdef STALL_COUNT_EN
    logic [15:0] cnt_q;
`endif

    assign stall   = bus.i_busy | bus.d_busy;
    // J and BEQ share one target formula, so jump priority needs no mux
    assign redir   = bus.jump_en | bus.branch_en;
    assign seq     = pc_q + 32'd4;
    assign off_ext = {{(32-OFFSET_W){bus.offset[OFFSET_W-1]}}, bus.offset};
    assign tgt     = seq + (off_ext << 2);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= HOLD;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            pend_q   <= 1'b0;
            pend_tgt <= '0;
`ifdef STALL_COUNT_EN
            cnt_q    <= '0;
`endif
        end else begin
`ifdef STALL_COUNT_EN
            if (valid_q && stall && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
`endif
            case (state)
                HOLD: begin
                    pc_q    <= seq;
                    valid_q <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        pc_q <= redir ? tgt : seq;
                    end else begin
                        if (redir) begin
                            pend_tgt <= tgt;
                            pend_q   <= 1'b1;
                        end
                        state <= STALL;
                    end
                end
                STALL: begin
                    // decoder output is stale here; only the parked target counts
                    if (!stall) begin
                        if (pend_q) begin
                            pc_q   <= pend_tgt;
                            pend_q <= 1'b0;
                        end else begin
                            pc_q <= seq;
                        end
                        state <= RUN;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_valid         = valid_q;
    assign bus.stall            = stall;
    assign bus.redirect_pending = pend_q;
`ifdef STALL_COUNT_EN
    assign bus.stall_cycles     = cnt_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/wrap sequences, randomized run against a reference model.
module tb_pc_sequencer;
    logic CLK;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.OFFSET_W(8)) bus ();

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .OFFSET_W(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_stalled;
    logic [31:0] m_q[$];
    int          m_cnt;

    typedef struct {
        logic        ib;
        logic        db;
        logic        j;
        logic        b;
        logic [7:0]  off;
        logic [31:0] exp_pc;
        logic        exp_pend;
    } vec_t;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'hFFFF_FFFC;
        m_valid = 1'b0;
        m_stalled = 1'b0;
        m_q.delete();
        m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        st;
        logic        rd;
        seq = m_pc + 32'd4;
        tgt = seq + 32'(int'($signed(bus.offset)) * 4);
        st  = bus.i_busy | bus.d_busy;
        rd  = bus.jump_en | bus.branch_en;
        if (m_valid && st && m_cnt < 65535) m_cnt++;
        if (!m_valid) begin
            m_pc = seq;
            m_valid = 1'b1;
        end else if (st) begin
            if (!m_stalled && rd) m_q.push_back(tgt);
            m_stalled = 1'b1;
        end else begin
            if (m_stalled) begin
                if (m_q.size() > 0) m_pc = m_q.pop_front();
                else m_pc = seq;
            end else begin
                m_pc = rd ? tgt : seq;
            end
            m_stalled = 1'b0;
        end
    endtask

    task automatic drive(input logic ib, input logic db, input logic j, input logic b, input logic [7:0] off);
        bus.i_busy    = ib;
        bus.d_busy    = db;
        bus.jump_en   = j;
        bus.branch_en = b;
        bus.offset    = off;
    endtask

    // Called at posedge+1: settle, check combinational stall, advance model, sample after next edge.
    task automatic tick();
        #1;
        chk("stall", {31'd0, bus.stall}, {31'd0, bus.i_busy | bus.d_busy});
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic async_reset_pulse();
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("rst_pc", bus.pc, 32'hFFFF_FFFC);
        chk("rst_valid", {31'd0, bus.pc_valid}, 32'd0);
        chk("rst_pend", {31'd0, bus.redirect_pending}, 32'd0);
        #1;
        RESET_N = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 32'd24, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 32'd20, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFD, 32'd12, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd16, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 32'd16, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 32'd16, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h7F, 32'd16, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd40, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd44, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hF8, 32'd16, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 32'd16, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 32'd16, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 32'd20, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 32'd20, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd28, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd32, 1'b0};

        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_pc", bus.pc, 32'hFFFF_FFFC);
        chk("reset_valid", {31'd0, bus.pc_valid}, 32'd0);
        chk("reset_pend", {31'd0, bus.redirect_pending}, 32'd0);
        RESET_N = 1'b1;

        // Directed vectors: sequential fetch, branches, stalled jump, stale branch, 1-cycle stall
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].ib, tbl[i].db, tbl[i].j, tbl[i].b, tbl[i].off);
            tick();
            chk($sformatf("vec%0d_pc", i), bus.pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_pend", i), {31'd0, bus.redirect_pending}, {31'd0, tbl[i].exp_pend});
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.pc_valid}, 32'd1);
        end
`ifdef STALL_COUNT_EN
        chk("vec_stall_cycles", {16'd0, bus.stall_cycles}, 32'd6);
`endif

        // Reset while a redirect is parked
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
        tick();
        chk("park_pc", bus.pc, 32'd32);
        chk("park_pend", {31'd0, bus.redirect_pending}, 32'd1);
        async_reset_pulse();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("resume0", bus.pc, 32'd0);
        tick();
        chk("resume1", bus.pc, 32'd4);
        tick();
        chk("resume2", bus.pc, 32'd8);

        // Backward wrap to FFFFFFF8, then forward wrap to 0
        async_reset_pulse();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("wrap_start", bus.pc, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFD);
        tick();
        chk("wrap_back", bus.pc, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        tick();
        chk("wrap_fwd", bus.pc, 32'h0000_0000);

        // Five-cycle stall with nothing pending
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) tick();
        chk("stall5_pc", bus.pc, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef STALL_COUNT_EN
        chk("stall5_count", {16'd0, bus.stall_cycles}, 32'd5);
`endif
        tick();
        chk("stall5_release", bus.pc, 32'd4);

        // Randomized run against the reference model
        async_reset_pulse();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
                  ($urandom % 5) == 0, 8'($urandom));
            tick();
            chk("rnd_pc", bus.pc, m_pc);
            chk("rnd_valid", {31'd0, bus.pc_valid}, {31'd0, m_valid});
            chk("rnd_pend", {31'd0, bus.redirect_pending}, {31'd0, (m_q.size() > 0)});
`ifdef STALL_COUNT_EN
            chk("rnd_stall_cycles", {16'd0, bus.stall_cycles}, 32'(m_cnt));
`endif
            if (($urandom % 250) == 0) async_reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequencing controller for the CPU program counter. It generates PC+4 every cycle and forms the J/BEQ target as PC+4 plus the sign-extended word offset shifted left by 2, using the same signed-offset add as the target adder. It holds the PC while the instruction or data cache reports busy, and it keeps a redirect that arrives during a stall so the redirect is not lost. It sits between the instruction decoder/ALU zero flag and the instruction cache address port.

Parameters:
RESET_PC, 32'hFFFF_FFFC, PC value loaded on reset; the first advance yields 0.
OFFSET_W, 8, width of the signed word offset field from the instruction.

Ports:
CLK  input  1  system clock, rising-edge.
RESET_N  input  1  asynchronous, active-low reset.
i_busy  input  1  instruction cache busy; the PC must hold.
d_busy  input  1  data cache busy; the PC must hold.
jump_en  input  1  decoded J instruction in the current cycle.
branch_en  input  1  decoded BEQ with ALU zero=1 (branch taken).
offset  input  OFFSET_W  signed word offset from the instruction.
pc  output  32  current fetch address.
pc_valid  output  1  pc is a real fetch address.
stall  output  1  i_busy|d_busy as seen by the sequencer; combinational.
redirect_pending  output  1  a target is latched and waiting for the stall to end.

Behaviour:
- Interface: one clock, CLK. RESET_N is asynchronous and active-low.
- Reset (RESET_N=0, asynchronous):
  - pc=RESET_PC, pc_valid=0, redirect_pending=0.
  - Pending target register cleared; state=HOLD.
  - This applies at any time, including mid-stall with a redirect pending; the pending redirect is discarded.
- Arithmetic:
  - seq = pc+4.
  - tgt = pc+4 + (sign_extend(offset) << 2).
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent in both directions.
- redir = jump_en|branch_en. When both are high, jump_en has priority; the target formula is identical either way.
- States:
  - HOLD: first edge after reset release. pc<=seq, pc_valid<=1, go to RUN. Inputs are ignored.
  - RUN, stall=0: pc<=redir ? tgt : seq. Next-PC latency is one edge.
  - RUN, stall=1: pc holds. If redir=1, latch tgt into the pending register, set redirect_pending=1, go to STALL. If redir=0, go to STALL with nothing pending.
  - STALL, stall=1: pc holds. jump_en/branch_en are ignored; the decoder output is considered stale. Pending is unchanged.
  - STALL, stall=0: if redirect_pending=1, pc<=pending and redirect_pending<=0. Otherwise pc<=seq. Go to RUN.
- pc_valid stays 1 from the HOLD->RUN edge until the next reset.
- The pending register is written only on the RUN->STALL edge; it is never overwritten while in STALL.
- A stall that is 1 for a single cycle behaves exactly as described above: one held edge, then release.
- Outputs are registered, except stall.

Optional Feature:
STALL_COUNT_EN
- Defined: adds output stall_cycles [15:0]. It increments on every edge where pc_valid=1 and stall=1, and saturates at 16'hFFFF. Reset value is 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset release, no stalls, no redirects -> pc sequence FFFFFFFC (pc_valid=0), then 0, 4, 8, 12 on successive edges.
2. At pc=8, branch_en=1 and offset=8'h03 for one cycle -> next pc=24 (8+4+12). With offset=8'hFE at pc=24 -> next pc=20 (24+4-8).
3. At pc=16, jump_en=1, offset=8'h05, i_busy=1 for 3 cycles -> pc holds at 16 and redirect_pending=1 for 3 edges. On release, pc=40, then 44.
4. At pc=16, d_busy=1 for 2 cycles, branch_en toggling during STALL -> pc holds, redirect_pending=0; on release pc=20 (branch ignored).
5. RESET_N pulsed low mid-STALL with a redirect pending -> pc=FFFFFFFC, pc_valid=0, redirect_pending=0 immediately (asynchronously); the resume sequence matches scenario 1.
6. pc=FFFFFFF8 with branch offset=8'h01 -> pc=00000000 (wrap). With STALL_COUNT_EN, 5 stall cycles -> stall_cycles=5.
